// File: rtl/oka_pkg.sv
// Shared types and helpers for the digit-serial carry-less multiplier.
// States, mode encodings and a generic W x D carry-less partial-product function.
package oka_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_GF   = 1'b1;

    localparam int WIDTH_DEF = 8;
    localparam int DIGIT_DEF = 1;
    localparam int NDIG_DEF  = WIDTH_DEF / DIGIT_DEF;
    localparam int MAXW      = 32;

    // Widest-case helper; dbits selects how many low bits of d form the digit.
    function automatic logic [2*MAXW-1:0] clmul_w_d(input logic [MAXW-1:0] x,
                                                    input logic [MAXW-1:0] d,
                                                    input int dbits);
        logic [2*MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < dbits && d[i]) begin
                r = r ^ ({{MAXW{1'b0}}, x} << i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/oka_clmul_digit.sv
// Combinational W x D carry-less partial product, shifted to digit position idx
// and XORed into the running 2W-bit accumulator.
module oka_clmul_digit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1,
    parameter int CW    = 3
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [DIGIT-1:0]   digit,
    input  logic [CW-1:0]      idx,
    input  logic [2*WIDTH-1:0] acc_in,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [2*WIDTH-1:0] part;

    always_comb begin
        part = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (digit[i]) begin
                part = part ^ ({{WIDTH{1'b0}}, a} << i);
            end
        end
        acc_out = acc_in ^ (part << (DIGIT * int'(idx)));
    end

endmodule

// File: rtl/oka_clmul_seq.sv
// Digit-serial carry-less multiplier with optional reduction mod x^W + POLY.
// Valid/ready on both sides; one operation in flight at a time.
module oka_clmul_seq
    import oka_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DIGIT = 1,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1B)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = $clog2(2 * WIDTH);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("oka_clmul_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               mode_q;
    logic [2*WIDTH-1:0] acc, mul_next, red_next;
    logic [CW-1:0]      cnt;
    logic               last_digit;

    assign last_digit = (cnt == CW'(NDIG - 1));

    oka_clmul_digit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT),
        .CW    (CW)
    ) u_digit (
        .a       (a_q),
        .digit   (b_q[DIGIT*int'(cnt) +: DIGIT]),
        .idx     (cnt),
        .acc_in  (acc),
        .acc_out (mul_next)
    );

    // Reduction walks D bits per cycle from the top, clearing each set bit in order.
    always_comb begin
        logic [AW-1:0] j;
        red_next = acc;
        j        = '0;
        for (int i = 0; i < DIGIT; i++) begin
            j = AW'(2*WIDTH - 1 - DIGIT*int'(cnt) - i);
            if (red_next[j]) begin
                red_next = red_next ^ ({{(WIDTH-1){1'b0}}, 1'b1, POLY} << (int'(j) - WIDTH));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MUL;
            end
            MUL: begin
                if (last_digit) state_next = (mode_q == MODE_GF) ? RED : DONE;
            end
            RED: begin
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter wraps after the last MUL digit so RED starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_FULL;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= mode;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= last_digit ? '0 : cnt + 1'b1;
                end
                RED: begin
                    acc <= red_next;
                    cnt <= last_digit ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign y = acc;

endmodule

// File: tb/tb_oka_clmul_seq.sv
// Directed and random checks of oka_clmul_seq at D=1 (unit 0) and D=4 (unit 1).
module tb_oka_clmul_seq;

    localparam int TIMEOUT = 200;

    typedef struct {
        int          u;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        mode;
        logic [15:0] exp_y;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [7:0]  a_s         [2];
    logic [7:0]  b_s         [2];
    logic        mode_s      [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [15:0] y_s         [2];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    oka_clmul_seq #(.WIDTH(8), .DIGIT(1), .POLY(8'h1B)) dut_d1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .a         (a_s[0]),
        .b         (b_s[0]),
        .mode      (mode_s[0]),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .y         (y_s[0])
    );

    oka_clmul_seq #(.WIDTH(8), .DIGIT(4), .POLY(8'h1B)) dut_d4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .a         (a_s[1]),
        .b         (b_s[1]),
        .mode      (mode_s[1]),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .y         (y_s[1])
    );

    // Reference: schoolbook product for mode 0, shift-and-xtime GF(2^8) product for mode 1.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] z, input logic m);
        logic [15:0] r;
        logic [7:0]  t, g;
        r = '0;
        if (!m) begin
            for (int i = 0; i < 8; i++) if (z[i]) r = r ^ ({8'h00, x} << i);
        end else begin
            t = x;
            g = '0;
            for (int i = 0; i < 8; i++) begin
                if (z[i]) g = g ^ t;
                t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
            end
            r = {8'h00, g};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int u, input logic [7:0] x, input logic [7:0] z, input logic m);
        @(negedge clk);
        in_valid_s[u] = 1'b1;
        a_s[u]        = x;
        b_s[u]        = z;
        mode_s[u]     = m;
        @(posedge clk);
        #1;
        in_valid_s[u] = 1'b0;
    endtask

    task automatic waitValid(input int u, input string name, output int cycles, output bit ok);
        cycles = 0;
        while (!out_valid_s[u] && cycles < TIMEOUT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        ok = out_valid_s[u];
        if (!ok) begin
            tests++;
            failed++;
            $display("[TB] FAIL %s_timeout: out_valid still 0 after %0d cycles", name, cycles);
        end
    endtask

    task automatic runOp(input int u, input logic [7:0] x, input logic [7:0] z, input logic m,
                         input logic [15:0] exp_y, input int exp_lat, input string name);
        int cycles;
        bit ok;
        applyStimulus(u, x, z, m);
        waitValid(u, name, cycles, ok);
        if (ok) begin
            checkOutput(name, y_s[u], exp_y);
            if (exp_lat > 0) checkOutput({name, "_lat"}, 16'(cycles), 16'(exp_lat));
        end
        out_ready_s[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[u] = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        int cycles;
        bit ok;
        logic [7:0] ra, rb;
        logic rm;

        vecs[0] = '{0, 8'h53, 8'hCA, 1'b0, 16'h3F7E, 8};
        vecs[1] = '{0, 8'h53, 8'hCA, 1'b1, 16'h0001, 16};
        vecs[2] = '{0, 8'hFF, 8'hFF, 1'b0, 16'h5555, 8};
        vecs[3] = '{0, 8'h02, 8'h80, 1'b1, 16'h001B, 16};
        vecs[4] = '{1, 8'h53, 8'hCA, 1'b0, 16'h3F7E, 2};
        vecs[5] = '{1, 8'h53, 8'hCA, 1'b1, 16'h0001, 4};
        vecs[6] = '{0, 8'h00, 8'hAB, 1'b0, 16'h0000, 8};
        vecs[7] = '{0, 8'h01, 8'hFF, 1'b1, 16'h00FF, 16};
        vecs[8] = '{1, 8'h80, 8'h80, 1'b0, 16'h4000, 2};
        vecs[9] = '{0, 8'h80, 8'h80, 1'b1, 16'h009A, 16};

        for (int u = 0; u < 2; u++) begin
            in_valid_s[u]  = 1'b0;
            out_ready_s[u] = 1'b0;
            a_s[u]         = '0;
            b_s[u]         = '0;
            mode_s[u]      = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("reset_in_ready_u%0d", u), 16'(in_ready_s[u]), 16'h1);
            checkOutput($sformatf("reset_out_valid_u%0d", u), 16'(out_valid_s[u]), 16'h0);
            checkOutput($sformatf("reset_y_u%0d", u), y_s[u], 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].u, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_y, vecs[i].exp_lat,
                  $sformatf("vec%0d", i));
        end

        // Backpressure: result held in DONE while a competing in_valid is ignored.
        applyStimulus(0, 8'h53, 8'hCA, 1'b0);
        waitValid(0, "bp", cycles, ok);
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        a_s[0]        = 8'hFF;
        b_s[0]        = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_y_c%0d", k), y_s[0], 16'h3F7E);
            checkOutput($sformatf("bp_valid_c%0d", k), 16'(out_valid_s[0]), 16'h1);
            checkOutput($sformatf("bp_in_ready_c%0d", k), 16'(in_ready_s[0]), 16'h0);
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s[0] = 1'b0;
        checkOutput("bp_in_ready_after", 16'(in_ready_s[0]), 16'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_no_spurious_op", 16'(out_valid_s[0]), 16'h0);

        // Reset during the third MUL cycle discards the operation.
        applyStimulus(0, 8'h53, 8'hCA, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", 16'(out_valid_s[0]), 16'h0);
        checkOutput("rst_mid_in_ready", 16'(in_ready_s[0]), 16'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_after_in_ready", 16'(in_ready_s[0]), 16'h1);
        checkOutput("rst_after_out_valid", 16'(out_valid_s[0]), 16'h0);
        checkOutput("rst_after_y", y_s[0], 16'h0000);
        runOp(0, 8'h03, 8'h03, 1'b0, 16'h0005, 8, "rst_next_op");

        // Random operations on both digit sizes against the reference model.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            runOp(n % 2, ra, rb, rm, ref_mul(ra, rb, rm), 0, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
